// File: rtl/softmax_pkg.sv
// Shared types and default sizing for the softmax normalisation datapath.
package softmax_pkg;

    typedef enum logic [2:0] {
        LOAD,
        ISSUE,
        WAIT,
        OUTPUT,
        CLEAR
    } norm_state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_N_MAX      = 8;
    localparam int SUM_W          = DEF_DATA_WIDTH;
    localparam int IDX_W          = $clog2(DEF_N_MAX) + 1;

endpackage

// File: rtl/softmax_norm_seq.sv
// Buffers one vector of exp values, sums them, then divides each element by the
// sum through an external sequential divider and streams Q0.FRAC_BITS results.
module softmax_norm_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int EXP_WIDTH  = DATA_WIDTH - FRAC_BITS,
    parameter int N_MAX      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FRAC_BITS:0]    out_data,
    output logic                  out_last,
    output logic                  div_start,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic                  div_done,
    output logic                  div_clr_n
);
    import softmax_pkg::*;

    localparam int ACC_W = DATA_WIDTH;
    localparam int CNT_W = $clog2(N_MAX) + 1;
    localparam int AW    = $clog2(N_MAX);

    if ((longint'(N_MAX) * ((longint'(1) << EXP_WIDTH) - 1)) >= (longint'(1) << DATA_WIDTH)) begin : g_sum_range_check
        $error("softmax_norm_seq: vector sum can overflow DATA_WIDTH");
    end
    if (EXP_WIDTH + FRAC_BITS != DATA_WIDTH || N_MAX < 2) begin : g_shape_check
        $error("softmax_norm_seq: unsupported parameter combination");
    end

    norm_state_t          state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [ACC_W-1:0]     sum_q, sum_d;
    logic [EXP_WIDTH-1:0] elem_q, elem_d;
    logic [FRAC_BITS:0]   out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [EXP_WIDTH-1:0] elem_buf_q [N_MAX];
    logic [EXP_WIDTH-1:0] elem_buf_d [N_MAX];

    logic                 is_last;
    logic                 advance;
    logic [CNT_W-1:0]     idx_next;
    logic                 unused_quotient_hi;

    assign is_last            = (idx_q == count_q - CNT_W'(1));
    assign idx_next           = idx_q + CNT_W'(1);
    assign unused_quotient_hi = ^div_quotient[DATA_WIDTH-1:FRAC_BITS+1];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        elem_d     = elem_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        elem_buf_d = elem_buf_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        div_start  = 1'b0;
        div_clr_n  = 1'b1;
        advance    = 1'b0;

        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    elem_buf_d[count_q[AW-1:0]] = in_data;
                    sum_d   = sum_q + ACC_W'(in_data);
                    count_d = count_q + CNT_W'(1);
                    if (in_last || count_q == CNT_W'(N_MAX - 1)) begin
                        idx_d   = '0;
                        // A one-element vector is still in flight on in_data, not yet in the buffer.
                        elem_d  = (count_q == '0) ? in_data : elem_buf_q[0];
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (sum_q == '0) begin
                    out_data_d = '0;
                    out_last_d = is_last;
                    state_d    = OUTPUT;
                end else begin
                    div_start = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (div_done) begin
                    out_data_d = div_quotient[FRAC_BITS:0];
                    out_last_d = is_last;
                    state_d    = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (sum_q != '0) begin
                        state_d = CLEAR;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            CLEAR: begin
                div_clr_n = 1'b0;
                advance   = 1'b1;
            end
            default: state_d = LOAD;
        endcase

        if (advance) begin
            if (out_last_q) begin
                count_d = '0;
                sum_d   = '0;
                state_d = LOAD;
            end else begin
                idx_d   = idx_next;
                elem_d  = elem_buf_q[idx_next[AW-1:0]];
                state_d = ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            count_q    <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            elem_q     <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            elem_q     <= elem_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        elem_buf_q <= elem_buf_d;
    end

    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign div_dividend = {elem_q, {FRAC_BITS{1'b0}}};
    assign div_divisor  = sum_q;

endmodule

// File: tb/tb_softmax_norm_seq.sv
// Randomised bench for softmax_norm_seq with a behavioural divider and a
// plain-arithmetic reference model of the expected probabilities.
module tb_softmax_norm_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_data;
    logic        out_last;
    logic        div_start;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic [15:0] div_quotient;
    logic        div_done;
    logic        div_clr_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    softmax_norm_seq #(
        .DATA_WIDTH(16),
        .FRAC_BITS (8),
        .N_MAX     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .div_start   (div_start),
        .div_dividend(div_dividend),
        .div_divisor (div_divisor),
        .div_quotient(div_quotient),
        .div_done    (div_done),
        .div_clr_n   (div_clr_n)
    );

    // Behavioural sequential divider with random latency, reset by rst_n & div_clr_n.
    logic        div_rst_n;
    logic        dbusy;
    int          dlat;
    logic [15:0] da, db;
    assign div_rst_n = rst_n & div_clr_n;

    always @(posedge clk or negedge div_rst_n) begin
        if (!div_rst_n) begin
            dbusy        <= 1'b0;
            div_done     <= 1'b0;
            div_quotient <= '0;
            dlat         <= 0;
        end else if (dbusy) begin
            if (dlat == 0) begin
                dbusy        <= 1'b0;
                div_done     <= 1'b1;
                div_quotient <= da / db;
            end else begin
                dlat <= dlat - 1;
            end
        end else if (div_start && !div_done) begin
            dbusy <= 1'b1;
            da    <= div_dividend;
            db    <= div_divisor;
            dlat  <= int'($urandom_range(0, 4));
        end
    end

    int start_cnt = 0;
    int clr_cnt = 0;
    int dvd_log[$];
    int dvs_log[$];
    always @(posedge clk) begin
        if (div_start === 1'b1) begin
            start_cnt++;
            dvd_log.push_back(int'(div_dividend));
            dvs_log.push_back(int'(div_divisor));
        end
        if (rst_n === 1'b1 && div_clr_n === 1'b0) clr_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: each probability is floor(v * 2^8 / sum), 0 when the sum is 0.
    int vec[$];
    int exp_d[$];
    int exp_starts;

    task automatic model();
        int sum = 0;
        exp_d.delete();
        exp_starts = 0;
        foreach (vec[i]) sum += vec[i];
        foreach (vec[i]) begin
            if (sum == 0) exp_d.push_back(0);
            else begin
                exp_d.push_back((vec[i] * 256) / sum);
                exp_starts++;
            end
        end
    endtask

    task automatic send_beat(input int v, input bit last, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = 8'(v);
        in_last = last;
        for (int t = 0; t < 2000; t++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_vec(input bit close, output bit ok);
        bit b;
        ok = 1'b1;
        foreach (vec[i]) begin
            send_beat(vec[i], close && (i == vec.size() - 1), b);
            ok &= b;
        end
    endtask

    logic [8:0] got_d[$];
    logic       got_l[$];
    int         ready_bad;
    int         stall_bad;
    bit         tmo;

    task automatic collect(input int n, input int stall_at, input bit rnd);
        int t = 0;
        int stall_left = 5;
        int snap = 0;
        int exp_stall;
        got_d.delete();
        got_l.delete();
        ready_bad = 0;
        stall_bad = 0;
        exp_stall = (stall_at >= 0 && stall_at < exp_d.size()) ? exp_d[stall_at] : 0;
        while (got_d.size() < n && t < 3000) begin
            if (in_ready !== 1'b0) ready_bad++;
            if (out_valid === 1'b1 && got_d.size() == stall_at && stall_left > 0) begin
                if (stall_left == 5) snap = start_cnt;
                out_ready = 1'b0;
                if (out_data !== 9'(exp_stall) || start_cnt != snap) stall_bad++;
                stall_left--;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (out_valid === 1'b1 && out_ready) begin
                    got_d.push_back(out_data);
                    got_l.push_back(out_last);
                end
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1'b1;
        tmo = (got_d.size() < n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_last, div_start, div_clr_n} !== 5'b10001) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=10001", {in_ready, out_valid, out_last, div_start, div_clr_n});
        end
        checks++;
        if (out_data !== 9'd0) begin
            failures++;
            $display("FAIL reset_data got=%0d exp=0", out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_uniform();
        bit ok;
        int s0 = start_cnt, c0 = clr_cnt;
        vec = '{64, 64, 64, 64};
        model();
        send_vec(1'b1, ok);
        collect(exp_d.size(), -1, 1'b0);
        @(negedge clk);
        checks++;
        if (!ok || tmo || got_d.size() != exp_d.size()) begin
            failures++;
            $display("FAIL uniform_count got=%0d exp=%0d", got_d.size(), exp_d.size());
        end else foreach (exp_d[i]) begin
            checks++;
            if (got_d[i] !== 9'(exp_d[i]) || got_l[i] !== (i == exp_d.size() - 1)) begin
                failures++;
                $display("FAIL uniform_out[%0d] got=%0d last=%b exp=%0d", i, got_d[i], got_l[i], exp_d[i]);
            end
        end
        checks++;
        if (start_cnt - s0 != 4 || clr_cnt - c0 != 4) begin
            failures++;
            $display("FAIL uniform_pulses got start=%0d clr=%0d exp 4/4", start_cnt - s0, clr_cnt - c0);
        end
        checks++;
        if (ready_bad != 0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL uniform_ready got busy_ready=%0d in_ready=%b out_valid=%b exp 0/1/0", ready_bad, in_ready, out_valid);
        end
    endtask

    task automatic test_edge_sum();
        bit ok;
        int s0 = start_cnt;
        vec = '{255, 1};
        model();
        send_vec(1'b1, ok);
        collect(exp_d.size(), -1, 1'b0);
        @(negedge clk);
        checks++;
        if (!ok || tmo || got_d.size() != 2) begin
            failures++;
            $display("FAIL edge_count got=%0d exp=2", got_d.size());
        end else foreach (exp_d[i]) begin
            checks++;
            if (got_d[i] !== 9'(exp_d[i]) || got_l[i] !== (i == 1)) begin
                failures++;
                $display("FAIL edge_out[%0d] got=%0d last=%b exp=%0d", i, got_d[i], got_l[i], exp_d[i]);
            end
        end
        checks++;
        if (dvd_log.size() < s0 + 2) begin
            failures++;
            $display("FAIL edge_operands got %0d starts exp 2", dvd_log.size() - s0);
        end else foreach (vec[i]) begin
            checks++;
            if (dvd_log[s0 + i] != (vec[i] << 8) || dvs_log[s0 + i] != 256) begin
                failures++;
                $display("FAIL edge_operand[%0d] got dividend=%h divisor=%h exp %h/0100", i, dvd_log[s0 + i], dvs_log[s0 + i], vec[i] << 8);
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        vec = '{10};
        model();
        send_vec(1'b1, ok);
        collect(1, -1, 1'b0);
        @(negedge clk);
        checks++;
        if (!ok || tmo || got_d.size() != 1 || got_d[0] !== 9'd256 || got_l[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_out got=%0d last=%b exp=256 last=1", got_d.size() > 0 ? got_d[0] : 9'h1ff, got_l.size() > 0 ? got_l[0] : 1'b0);
        end
    endtask

    task automatic test_zeros();
        bit ok;
        int s0 = start_cnt, c0 = clr_cnt;
        vec = '{0, 0, 0};
        model();
        send_vec(1'b1, ok);
        collect(3, -1, 1'b0);
        checks++;
        if (!ok || tmo || got_d.size() != 3) begin
            failures++;
            $display("FAIL zeros_count got=%0d exp=3", got_d.size());
        end else foreach (exp_d[i]) begin
            checks++;
            if (got_d[i] !== 9'(exp_d[i]) || got_l[i] !== (i == 2)) begin
                failures++;
                $display("FAIL zeros_out[%0d] got=%0d last=%b exp=%0d", i, got_d[i], got_l[i], exp_d[i]);
            end
        end
        checks++;
        if (start_cnt != s0 || clr_cnt != c0) begin
            failures++;
            $display("FAIL zeros_pulses got start=%0d clr=%0d exp 0/0", start_cnt - s0, clr_cnt - c0);
        end
        checks++;
        if (ready_bad != 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL zeros_ready got busy_ready=%0d in_ready=%b exp 0/1", ready_bad, in_ready);
        end
    endtask

    task automatic test_forced_last();
        bit ok, ok2;
        int s0 = start_cnt;
        vec.delete();
        for (int i = 0; i < 8; i++) vec.push_back(int'($urandom_range(1, 255)));
        model();
        send_vec(1'b0, ok);
        collect(8, 3, 1'b0);
        @(negedge clk);
        checks++;
        if (!ok || tmo || got_d.size() != 8) begin
            failures++;
            $display("FAIL forced_count got=%0d exp=8", got_d.size());
        end else foreach (exp_d[i]) begin
            checks++;
            if (got_d[i] !== 9'(exp_d[i]) || got_l[i] !== (i == 7)) begin
                failures++;
                $display("FAIL forced_out[%0d] got=%0d last=%b exp=%0d", i, got_d[i], got_l[i], exp_d[i]);
            end
        end
        checks++;
        if (stall_bad != 0 || start_cnt - s0 != 8) begin
            failures++;
            $display("FAIL forced_stall got unstable=%0d starts=%0d exp 0/8", stall_bad, start_cnt - s0);
        end
        vec = '{int'($urandom_range(1, 255)), int'($urandom_range(0, 255))};
        model();
        send_beat(vec[0], 1'b0, ok);
        send_beat(vec[1], 1'b1, ok2);
        collect(2, -1, 1'b0);
        @(negedge clk);
        checks++;
        if (!ok || !ok2 || tmo || got_d.size() != 2) begin
            failures++;
            $display("FAIL forced_next_count got=%0d exp=2", got_d.size());
        end else foreach (exp_d[i]) begin
            checks++;
            if (got_d[i] !== 9'(exp_d[i]) || got_l[i] !== (i == 1)) begin
                failures++;
                $display("FAIL forced_next_out[%0d] got=%0d last=%b exp=%0d", i, got_d[i], got_l[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int seen = 0;
        int bad = 0;
        vec = '{100, 50};
        send_vec(1'b1, ok);
        for (int t = 0; t < 50 && seen == 0; t++) begin
            if (div_start === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!ok || seen == 0) begin
            failures++;
            $display("FAIL rstwait_start got start_seen=%0d exp=1", seen);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, div_start, div_clr_n} !== 5'b10001 || out_data !== 9'd0) begin
            failures++;
            $display("FAIL rstwait_values got ctrl=%b data=%0d exp 10001/0",
                     {in_ready, out_valid, out_last, div_start, div_clr_n}, out_data);
        end
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || div_start !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstwait_quiet got bad_cycles=%0d exp=0", bad);
        end
        vec = '{128, 128};
        model();
        send_vec(1'b1, ok);
        collect(2, -1, 1'b0);
        @(negedge clk);
        checks++;
        if (!ok || tmo || got_d.size() != 2) begin
            failures++;
            $display("FAIL rstwait_next_count got=%0d exp=2", got_d.size());
        end else foreach (exp_d[i]) begin
            checks++;
            if (got_d[i] !== 9'(exp_d[i]) || got_l[i] !== (i == 1)) begin
                failures++;
                $display("FAIL rstwait_next_out[%0d] got=%0d last=%b exp=%0d", i, got_d[i], got_l[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int v = 0; v < 10; v++) begin
            int n = int'($urandom_range(1, 8));
            int s0 = start_cnt;
            bit zero_vec = ($urandom_range(0, 4) == 0);
            vec.delete();
            for (int i = 0; i < n; i++) vec.push_back(zero_vec ? 0 : int'($urandom_range(0, 255)));
            model();
            send_vec(1'b1, ok);
            collect(n, -1, 1'b1);
            @(negedge clk);
            checks++;
            if (!ok || tmo || got_d.size() != n) begin
                failures++;
                $display("FAIL random%0d_count got=%0d exp=%0d", v, got_d.size(), n);
            end else foreach (exp_d[i]) begin
                checks++;
                if (got_d[i] !== 9'(exp_d[i]) || got_l[i] !== (i == n - 1)) begin
                    failures++;
                    $display("FAIL random%0d_out[%0d] got=%0d last=%b exp=%0d", v, i, got_d[i], got_l[i], exp_d[i]);
                end
            end
            checks++;
            if (start_cnt - s0 != exp_starts || ready_bad != 0) begin
                failures++;
                $display("FAIL random%0d_starts got=%0d busy_ready=%0d exp=%0d/0", v, start_cnt - s0, ready_bad, exp_starts);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_uniform();
        test_edge_sum();
        test_single();
        test_zeros();
        test_forced_last();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/softmax_norm_seq.md
Name: softmax_norm_seq

Overview:
Normalisation sequencer for the softmax datapath. It buffers one vector of exponent values from the exp stage and accumulates their sum. It then drives the sequential divider once per element with dividend = exp << FRAC_BITS and divisor = sum. It streams the quotients out as Q0.FRAC_BITS probabilities, and sits between the exp stage (upstream) and the divider (side port).

Parameters:
DATA_WIDTH, 16, divider operand width
FRAC_BITS, 8, fractional bits of output probability
EXP_WIDTH, DATA_WIDTH-FRAC_BITS (8), input exponent width
N_MAX, 8, max vector length (buffer depth)
Elaboration check: N_MAX*(2^EXP_WIDTH-1) < 2^DATA_WIDTH, so the sum never overflows.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  exp value valid
in_ready  out  1  sequencer accepting input
in_data  in  EXP_WIDTH  exp value
in_last  in  1  last element of vector
out_valid  out  1  probability valid
out_ready  in  1  downstream accepts
out_data  out  FRAC_BITS+1  quotient, range 0..2^FRAC_BITS
out_last  out  1  last probability of vector
div_start  out  1  divider start pulse
div_dividend  out  DATA_WIDTH  {buf[idx], FRAC_BITS zeros}
div_divisor  out  DATA_WIDTH  accumulated sum, zero-extended
div_quotient  in  DATA_WIDTH  divider result
div_done  in  1  divider result valid (level, held until divider cleared)
div_clr_n  out  1  sync clear to divider, active-low; top ANDs it with rst_n

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, div_start=0, div_clr_n=1.
- Reset clears state, count, idx and sum. The buffer contents need not be cleared.
- FSM states: LOAD, ISSUE, WAIT, OUTPUT, CLEAR.
- LOAD:
  - in_ready=1.
  - On in_valid: buf[count]<=in_data, sum<=sum+in_data, count++.
  - Go to ISSUE (idx=0) when in_last, or when the accepted element is the N_MAX-th. In the forced case in_last is ignored and the next beat starts a new vector.
  - in_ready=0 in every other state; no input is accepted while dividing.
- ISSUE:
  - If sum==0: skip the divider, set out_data=0, go to OUTPUT.
  - Else assert div_start for exactly 1 cycle, go to WAIT.
  - div_dividend and div_divisor are registered and stable from ISSUE through WAIT.
- WAIT:
  - Hold until div_done=1.
  - Capture out_data<=div_quotient[FRAC_BITS:0] and out_last<=(idx==count-1).
  - Go to OUTPUT.
- OUTPUT:
  - out_valid=1; out_data and out_last are held stable while out_ready=0.
  - On out_ready: out_valid drops next cycle. Go to CLEAR if the divider was used, else straight to the next element.
- CLEAR:
  - div_clr_n=0 for exactly 1 cycle so the divider returns to idle.
  - Then, if last: count<=0, sum<=0, go to LOAD. Else idx++, go to ISSUE.
- Arithmetic:
  - Quotient = floor(exp*2^FRAC_BITS/sum), always ≤ 2^FRAC_BITS because exp ≤ sum.
  - Sum width is DATA_WIDTH; no saturation is needed given the elaboration check.
- Per-element latency is ISSUE(1) + divider time + capture(1) + handshake + CLEAR(1). No fixed cycle count is assumed; div_done is authoritative.
- Reset mid-operation (any state, e.g. WAIT): immediate return to LOAD with counters zeroed. The partial vector is discarded and no out_valid is produced.

Decomposition:
- Package softmax_pkg:
  - state enum norm_state_t {LOAD, ISSUE, WAIT, OUTPUT, CLEAR}
  - localparam SUM_W = DATA_WIDTH
  - localparam IDX_W = $clog2(N_MAX)+1
- No sub-module needed. The buffer is a small register array inside the block.
- Top level instantiates this block next to the divider with the divider's rst_n = rst_n & div_clr_n.

Test Plan:
- Input [64,64,64,64] with last on the 4th beat, out_ready=1 -> four outputs of 64 (0.25 in Q0.8), out_last on the 4th only, 4 div_start pulses, 4 div_clr_n pulses.
- Input [255,1], sum 256 -> outputs 255 then 1; div_dividend=0xFF00 then 0x0100, div_divisor=0x0100.
- Single element [10] with last -> output 256 (1.0) with out_last=1.
- Input [0,0,0] -> three outputs of 0, no div_start or div_clr_n pulse, in_ready=0 until the third output is accepted.
- 9 beats with no in_last -> first 8 form a vector with out_last on the 8th output; the 9th beat begins the next vector. Hold out_ready=0 for 5 cycles mid-vector -> out_data stable and no extra div_start.
- Assert rst_n=0 while in WAIT -> all outputs return to reset values. After release, a new vector [128,128] yields 128,128.
